// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad constants, FSM states and key decode
package keypad_pkg;

  localparam logic [2:0] COL1 = 3'b001;
  localparam logic [2:0] COL2 = 3'b010;
  localparam logic [2:0] COL3 = 3'b100;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Returns {valid, col[2:0], row[3:0]}; codes 12-15 decode to all zeros.
  function automatic logic [7:0] key_to_colrow(input logic [3:0] code);
    logic [7:0] r;
    case (code)
      4'd1:     r = {1'b1, COL1, 4'b0001};
      4'd4:     r = {1'b1, COL1, 4'b0010};
      4'd7:     r = {1'b1, COL1, 4'b0100};
      KEY_STAR: r = {1'b1, COL1, 4'b1000};
      4'd2:     r = {1'b1, COL2, 4'b0001};
      4'd5:     r = {1'b1, COL2, 4'b0010};
      4'd8:     r = {1'b1, COL2, 4'b0100};
      4'd0:     r = {1'b1, COL2, 4'b1000};
      4'd3:     r = {1'b1, COL3, 4'b0001};
      4'd6:     r = {1'b1, COL3, 4'b0010};
      4'd9:     r = {1'b1, COL3, 4'b0100};
      KEY_HASH: r = {1'b1, COL3, 4'b1000};
      default:  r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - matrix keypad responder driven by a key request handshake
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES = 100000,
  parameter int GAP_CYCLES  = 100000,
  parameter int CNT_W       = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_col,
  output logic [3:0] key_row,
  input  logic       req_valid,
  input  logic [3:0] req_key,
  output logic       req_ready,
  output logic       done,
  output logic       hit,
  output logic       err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             seen;
  logic [2:0]       col_q;
  logic [3:0]       row_q;
  logic             done_q;
  logic             hit_q;
  logic             err_q;
  logic [7:0]       dec;

  assign dec = key_to_colrow(req_key);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      seen   <= 1'b0;
      col_q  <= 3'b000;
      row_q  <= 4'b0000;
      done_q <= 1'b0;
      hit_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      hit_q  <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (dec[7]) begin
              col_q <= dec[6:4];
              row_q <= dec[3:0];
              cnt   <= HOLD_LOAD;
              seen  <= 1'b0;
              state <= PRESS;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        PRESS: begin
          if (key_col == col_q) begin
            seen <= 1'b1;
          end
          if (cnt == '0) begin
            cnt   <= GAP_LOAD;
            state <= GAP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state  <= IDLE;
            done_q <= 1'b1;
            hit_q  <= seen;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // col_q is always one-hot while pressed, so equality also rejects 000 and multi-bit strobes.
  assign key_row   = (state == PRESS && key_col == col_q) ? row_q : 4'b0000;
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign hit       = hit_q;
  assign err       = err_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// tb/tb_keypad_emulator.sv - randomized self-checking bench for keypad_emulator
module tb_keypad_emulator;

  localparam int H = 8;
  localparam int G = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] key_col = 3'b000;
  logic [3:0] key_row;
  logic       req_valid = 1'b0;
  logic [3:0] req_key = 4'd0;
  logic       req_ready;
  logic       done;
  logic       hit;
  logic       err;
  logic       busy;

  keypad_emulator #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .key_col(key_col), .key_row(key_row),
    .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
    .done(done), .hit(hit), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  // Keypad layout from first principles: digits 1-9 fill rows left to right, bottom row is * 0 #.
  function automatic logic [2:0] m_colmask(input int k);
    int c;
    if (k >= 1 && k <= 9) c = (k - 1) % 3;
    else if (k == 0) c = 1;
    else if (k == 10) c = 0;
    else c = 2;
    return 3'(1 << c);
  endfunction

  function automatic logic [3:0] m_rowmask(input int k);
    int r;
    r = (k >= 1 && k <= 9) ? (k - 1) / 3 : 3;
    return 4'(1 << r);
  endfunction

  // Behavioural model: a press is just an acceptance time plus fixed windows.
  int cyc = 0;
  int c_prev;
  bit started = 0;
  bit m_active = 0;
  int m_t = 0;
  int m_key = 0;
  bit m_seen = 0;
  bit m_hit = 0;
  int m_done_cyc = -100;
  int m_err_cyc = -100;

  always @(posedge clk) begin
    c_prev = cyc;
    if (rst) begin
      m_active   = 0;
      m_done_cyc = -100;
      m_err_cyc  = -100;
      started    = 1;
    end else begin
      if (m_active && c_prev >= m_t + 1 && c_prev <= m_t + H && key_col == m_colmask(m_key))
        m_seen = 1;
      if (!m_active && req_valid) begin
        if (int'(req_key) <= 11) begin
          m_active = 1;
          m_t      = c_prev;
          m_key    = int'(req_key);
          m_seen   = 0;
        end else begin
          m_err_cyc = c_prev + 1;
        end
      end
    end
    cyc = c_prev + 1;
    if (m_active && cyc == m_t + H + G + 1) begin
      m_active   = 0;
      m_done_cyc = cyc;
      m_hit      = m_seen;
    end
  end

  function automatic logic [3:0] exp_row();
    if (m_active && cyc >= m_t + 1 && cyc <= m_t + H && key_col == m_colmask(m_key))
      return m_rowmask(m_key);
    return 4'b0000;
  endfunction

  int t_row_nz = 0, t_row_not1 = 0, t_row_0010 = 0;
  int t_done = 0, t_err = 0, t_busy = 0;
  int last_done_at = -1;
  logic last_hit = 1'b0;

  always @(negedge clk) begin
    if (started) begin
      check("key_row", {28'd0, key_row}, {28'd0, exp_row()});
      check("req_ready", {31'd0, req_ready}, {31'd0, !m_active});
      check("busy", {31'd0, busy}, {31'd0, m_active});
      check("done", {31'd0, done}, {31'd0, (cyc == m_done_cyc)});
      check("hit", {31'd0, hit}, {31'd0, (cyc == m_done_cyc) ? m_hit : 1'b0});
      check("err", {31'd0, err}, {31'd0, (cyc == m_err_cyc)});
      if (key_row != 4'b0000) t_row_nz++;
      if (key_row != 4'b0000 && key_row != 4'b0001) t_row_not1++;
      if (key_row == 4'b0010) t_row_0010++;
      if (err) t_err++;
      if (busy) t_busy++;
      if (done) begin
        t_done++;
        last_hit     = hit;
        last_done_at = cyc;
      end
    end
  end

  int       col_mode = 0;
  logic [2:0] col_fixed = 3'b000;
  int       rot_idx = 0;

  always @(posedge clk) begin
    #2;
    case (col_mode)
      0: key_col = col_fixed;
      1: begin
        key_col = 3'(1 << ((rot_idx / 3) % 3));
        rot_idx++;
      end
      default: key_col = 3'($urandom_range(7, 0));
    endcase
  end

  task automatic send(input logic [3:0] k, output int acc);
    int c0;
    logic r;
    acc = -1;
    req_valid = 1'b1;
    req_key   = k;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      r  = req_ready;
      c0 = cyc;
      @(posedge clk);
      #2;
      if (r) begin
        acc = c0;
        break;
      end
    end
    req_valid = 1'b0;
    req_key   = 4'($urandom_range(15, 0));
    if (acc < 0) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int d0);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (t_done > d0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("done_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int a1, a2, b_nz, b_x, b_err, b_busy, d0;

  initial begin
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_key_row", {28'd0, key_row}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #2;

    // Key 5 with column 2 held: eight cycles of row 0010, done at T+13.
    col_mode = 0; col_fixed = 3'b010;
    idle(2);
    b_nz = t_row_nz; b_x = t_row_0010; d0 = t_done;
    send(4'd5, a1);
    wait_done(d0);
    check("t1_row_cycles", 32'(t_row_0010 - b_x), 32'd8);
    check("t1_nz_cycles", 32'(t_row_nz - b_nz), 32'd8);
    check("t1_done_lat", 32'(last_done_at - a1), 32'd13);
    check("t1_hit", {31'd0, last_hit}, 32'd1);

    // Key 1 with rotating columns.
    col_mode = 1;
    b_nz = t_row_nz; b_x = t_row_not1; d0 = t_done;
    send(4'd1, a1);
    wait_done(d0);
    check("t2_only_0001", 32'(t_row_not1 - b_x), 32'd0);
    check("t2_some_rows", {31'd0, (t_row_nz > b_nz)}, 32'd1);
    check("t2_hit", {31'd0, last_hit}, 32'd1);

    // '#' never strobed.
    col_mode = 0; col_fixed = 3'b001;
    idle(1);
    b_nz = t_row_nz; d0 = t_done;
    send(4'd11, a1);
    wait_done(d0);
    check("t3_no_rows", 32'(t_row_nz - b_nz), 32'd0);
    check("t3_hit", {31'd0, last_hit}, 32'd0);

    // Invalid code 13.
    b_err = t_err; b_busy = t_busy; b_nz = t_row_nz;
    send(4'd13, a1);
    idle(3);
    check("t4_err_count", 32'(t_err - b_err), 32'd1);
    check("t4_busy", 32'(t_busy - b_busy), 32'd0);
    check("t4_no_rows", 32'(t_row_nz - b_nz), 32'd0);

    // Back-to-back: second accepted in the first done cycle.
    col_mode = 2;
    d0 = t_done;
    send(4'd9, a1);
    send(4'd0, a2);
    check("t5_b2b", 32'(a2 - a1), 32'd13);
    check("t5_done_at_acc", 32'(last_done_at), 32'(a2));
    wait_done(d0 + 1);

    // Reset in the third press cycle.
    col_mode = 0; col_fixed = 3'b010;
    idle(1);
    send(4'd2, a1);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("t6_row", {28'd0, key_row}, 32'd0);
    check("t6_ready", {31'd0, req_ready}, 32'd1);
    check("t6_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #2;
    d0 = t_done;
    idle(20);
    check("t6_no_done", 32'(t_done), 32'(d0));

    // Randomized traffic with occasional resets.
    col_mode = 2;
    for (int i = 0; i < 40; i++) begin
      send(4'($urandom_range(15, 0)), a1);
      idle($urandom_range(3, 0));
      if ($urandom_range(9, 0) == 0) begin
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
      end
    end
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
